// File: rtl/mat_fill_loader_if.sv
// Avalon-MM read-master bundle (address/read/waitrequest/readdata/readdatavalid)
// shared by mat_fill_loader (master) and the memory it reads (slave).
interface mat_fill_loader_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_read;
  logic                  avm_waitrequest;
  logic [63:0]           avm_readdata;
  logic                  avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/mat_fill_loader.sv
// Loads a 9-word operand image over Avalon-MM and unpacks it byte-by-byte into
// eight A row FIFOs and one B FIFO. Define LOADER_ERR_EN for the read-timeout ERR state.
module mat_fill_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  mat_fill_loader_if.master      avm,
  output logic [7:0]             a_wren_out,
  output logic [7:0]             a_data_out [8],
  output logic                   b_wren_out,
  output logic [7:0]             b_data_out,
  input  logic [7:0]             a_full,
  input  logic                   b_full,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

`ifdef LOADER_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_UNPACK, S_DONE, S_ERR} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_UNPACK, S_DONE} state_e;
`endif

  state_e      r_state;
  state_e      w_next;
  logic [3:0]  r_index;
  logic [2:0]  r_byte;
  logic [63:0] r_hold;
  logic [7:0]  r_a_wren;
  logic [7:0]  r_a_data;
  logic        r_b_wren;
  logic [7:0]  r_b_data;

  logic        w_last_word;
  logic        w_last_byte;
  logic        w_target_full;
  logic [7:0]  w_a_we;
  logic        w_b_we;
  logic        w_write;
  logic [7:0]  w_byte;

`ifdef LOADER_ERR_EN
  logic [8:0]  r_tmo;
  logic        w_timeout;
`endif

  // Word 8 is the B vector; words 0..7 target the A row FIFO of the same index.
  assign w_last_word   = (r_index == 4'd8);
  assign w_last_byte   = (r_byte == 3'd7);
  assign w_target_full = w_last_word ? b_full : a_full[r_index[2:0]];
  assign w_write       = (|w_a_we) | w_b_we;
  assign w_byte        = r_hold[8*r_byte +: 8];

  assign avm.avm_address = BASE_ADDR + ADDR_WIDTH'({r_index, 3'b000});

`ifdef LOADER_ERR_EN
  assign w_timeout = (r_tmo == 9'd255) && !avm.avm_readdatavalid;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // w_next unassigned, which would infer a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_REQ;
      S_REQ:          if (!avm.avm_waitrequest) w_next = S_WAIT;
      S_WAIT: begin
        if (avm.avm_readdatavalid) w_next = S_UNPACK;
`ifdef LOADER_ERR_EN
        else if (w_timeout)        w_next = S_ERR;
`endif
      end
      S_UNPACK:
        if (w_write && w_last_byte) w_next = w_last_word ? S_DONE : S_REQ;
`ifdef LOADER_ERR_EN
      S_ERR:          if (start) w_next = S_REQ;
`endif
      default:        w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs and next-cycle write strobes
  always_comb begin
    avm.avm_read = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    w_a_we       = '0;
    w_b_we       = 1'b0;
    case (r_state)
      S_REQ: begin
        avm.avm_read = 1'b1;
        busy         = 1'b1;
      end
      S_WAIT:   busy = 1'b1;
      S_UNPACK: begin
        busy = 1'b1;
        if (!w_target_full) begin
          if (w_last_word) w_b_we = 1'b1;
          else             w_a_we[r_index[2:0]] = 1'b1;
        end
      end
      S_DONE:   done = 1'b1;
`ifdef LOADER_ERR_EN
      S_ERR:    err = 1'b1;
`endif
      default: ;
    endcase
  end

  // Word index, byte counter and holding register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the holding register is a plain 64-bit register, not a memory,
    // so it is reset along with the rest of the datapath.
    if (rst) begin
      r_index <= '0;
      r_byte  <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (start) r_index <= '0;
        S_WAIT: begin
          if (avm.avm_readdatavalid) begin
            r_hold <= avm.avm_readdata;
            r_byte <= '0;
          end
        end
        S_UNPACK: begin
          if (w_write) begin
            r_byte <= r_byte + 3'd1;
            if (w_last_byte && !w_last_word) r_index <= r_index + 4'd1;
          end
        end
`ifdef LOADER_ERR_EN
        S_ERR: if (start) r_index <= '0;
`endif
        default: ;
      endcase
    end
  end

`ifdef LOADER_ERR_EN
  // Counts WAIT cycles without a response; cleared whenever WAIT is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         r_tmo <= '0;
    else if (r_state == S_WAIT && !avm.avm_readdatavalid) r_tmo <= r_tmo + 9'd1;
    else                                             r_tmo <= '0;
  end
`endif

  // Registered FIFO write strobes and data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_wren <= '0;
      r_a_data <= '0;
      r_b_wren <= 1'b0;
      r_b_data <= '0;
    end else begin
      r_a_wren <= w_a_we;
      r_b_wren <= w_b_we;
      if (|w_a_we) r_a_data <= w_byte;
      if (w_b_we)  r_b_data <= w_byte;
    end
  end

  assign a_wren_out = r_a_wren;
  assign b_wren_out = r_b_wren;
  assign b_data_out = r_b_data;

  always_comb begin
    for (int i = 0; i < 8; i++) a_data_out[i] = r_a_data;
  end

endmodule

// File: tb/tb_mat_fill_loader.sv
// Scoreboard bench for mat_fill_loader: stimulus pushes expected reads/writes,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_mat_fill_loader;
  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_wren_out;
  logic [7:0] a_data_out [8];
  logic       b_wren_out;
  logic [7:0] b_data_out;
  logic [7:0] a_full;
  logic       b_full;
  logic       busy;
  logic       done;
  logic       err;

  mat_fill_loader_if #(.ADDR_WIDTH(AW)) avm_if ();

  mat_fill_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .avm        (avm_if),
    .a_wren_out (a_wren_out),
    .a_data_out (a_data_out),
    .b_wren_out (b_wren_out),
    .b_data_out (b_data_out),
    .a_full     (a_full),
    .b_full     (b_full),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_b;
    logic [2:0] row;
    logic [7:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] addr_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          a_cnt [8];
  int          b_cnt;
  int          w3_stalls;
  int          w3_accepts;
  logic [7:0]  prev_a_full;

  // memory-model knobs
  int          ws_left = 0;
  bit          stall_en = 1'b0;
  bit          no_resp_w0 = 1'b0;
  int          ucnt = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // image byte k of word w: A rows hold 8w+k, B word (w=8) holds 8'h40+k
  function automatic logic [63:0] image_word(input int w);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = 8'(8*w + k);
    return v;
  endfunction

  // Avalon slave: 1-cycle read latency, optional wait states / missing response
  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    avm_if.avm_waitrequest   = 1'b0;
    avm_if.avm_readdatavalid = 1'b0;
    avm_if.avm_readdata      = '0;
    a_full = '0;
    b_full = 1'b0;
    forever begin
      @(negedge clk);
      acc      = !rst && avm_if.avm_read && !avm_if.avm_waitrequest;
      acc_addr = avm_if.avm_address;
      @(posedge clk);
      #1;
      if (rst) begin
        avm_if.avm_readdatavalid = 1'b0;
        avm_if.avm_waitrequest   = 1'b0;
        a_full = '0;
        ucnt   = -1;
      end else begin
        avm_if.avm_readdatavalid = acc && !(no_resp_w0 && acc_addr == BASE);
        avm_if.avm_readdata      = acc ? image_word(int'((acc_addr - BASE) >> 3)) : 64'hDEAD_BEEF_DEAD_BEEF;
        if (avm_if.avm_read && avm_if.avm_address == BASE + 32'd24 && ws_left > 0) begin
          avm_if.avm_waitrequest = 1'b1;
          ws_left--;
        end else begin
          avm_if.avm_waitrequest = 1'b0;
        end
        if (ucnt >= 0) ucnt++;
        if (avm_if.avm_readdatavalid && acc_addr == BASE + 32'd16 && stall_en) begin
          ucnt     = 0;
          stall_en = 1'b0;
        end
        a_full    = '0;
        a_full[2] = (ucnt >= 4 && ucnt <= 9);
        if (ucnt > 9) ucnt = -1;
      end
    end
  end

  // Monitor: pops expected reads/writes as the DUT presents them
  always @(negedge clk) begin
    if (!rst) begin
      if (a_wren_out != 0 || b_wren_out) begin
        wr_t e;
        wr_t a;
        int  bad_lanes;
        check("one_strobe", 64'($countones({a_wren_out, b_wren_out})), 64'd1);
        a = '0;
        if (b_wren_out) begin
          a.is_b = 1'b1;
          a.data = b_data_out;
          b_cnt++;
        end else begin
          for (int i = 0; i < 8; i++) if (a_wren_out[i]) a.row = 3'(i);
          a.data = a_data_out[a.row];
          a_cnt[a.row]++;
        end
        bad_lanes = 0;
        for (int i = 0; i < 8; i++) if (a_data_out[i] !== a_data_out[0]) bad_lanes++;
        check("a_lanes_equal", 64'(bad_lanes), 64'd0);
        if (wr_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL wr_unexpected: got write %0h expected none at %0t", a, $time);
        end else begin
          e = wr_q.pop_front();
          check("wr_target", {a.is_b, a.row}, {e.is_b, e.row});
          check("wr_data", a.data, e.data);
        end
      end
      if (prev_a_full != 0) check("stall_no_strobe", a_wren_out & prev_a_full, 64'd0);
      if (avm_if.avm_read && avm_if.avm_address == BASE + 32'd24) begin
        if (avm_if.avm_waitrequest) w3_stalls++;
        else                        w3_accepts++;
      end
      if (avm_if.avm_read && avm_if.avm_waitrequest && addr_q.size() != 0)
        check("addr_stable", avm_if.avm_address, addr_q[0]);
      if (avm_if.avm_read && !avm_if.avm_waitrequest) begin
        if (addr_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL rd_unexpected: got read %0h expected none at %0t", avm_if.avm_address, $time);
        end else begin
          check("rd_addr", avm_if.avm_address, addr_q.pop_front());
        end
      end
    end
    prev_a_full = a_full;
  end

  time t0;

  task automatic issue_load(input bit full_image);
    wr_t e;
    wr_q.delete();
    addr_q.delete();
    for (int w = 0; w < 9; w++) begin
      addr_q.push_back(BASE + 32'(8 * w));
      if (full_image || w == 0) begin
        for (int k = 0; k < 8; k++) begin
          e.is_b = (w == 8);
          e.row  = (w == 8) ? 3'd0 : 3'(w);
          e.data = 8'(8 * w + k);
          if (full_image) wr_q.push_back(e);
        end
      end
      if (!full_image) break;
    end
    for (int i = 0; i < 8; i++) a_cnt[i] = 0;
    b_cnt      = 0;
    w3_stalls  = 0;
    w3_accepts = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    t0 = $time;
    #1;
    start = 1'b0;
    check("start_clears_done", done, 0);
    check("start_sets_busy", busy, 1);
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    time t1;
    int  guard;
    t1 = t0;
    guard = 0;
    while (!done && guard < 2000) begin
      @(posedge clk);
      t1 = $time;
      #1;
      guard++;
    end
    check({tag, "_latency"}, 64'((t1 - t0) / 10), 64'(exp_lat));
    check({tag, "_busy_in_done"}, busy, 0);
    @(negedge clk);
    #1;
    check({tag, "_wr_q_empty"}, 64'(wr_q.size()), 0);
    check({tag, "_addr_q_empty"}, 64'(addr_q.size()), 0);
    for (int i = 0; i < 8; i++) check({tag, "_a_count"}, 64'(a_cnt[i]), 8);
    check({tag, "_b_count"}, 64'(b_cnt), 8);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_wren"}, a_wren_out, 0);
    check({tag, "_b_wren"}, b_wren_out, 0);
    check({tag, "_a_data"}, a_data_out[5], 0);
    check({tag, "_b_data"}, b_data_out, 0);
    check({tag, "_avm_read"}, avm_if.avm_read, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    // watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) a_cnt[i] = 0;
    b_cnt = 0;
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // plain load with a start pulse ignored while busy
    issue_load(1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("busy_mid_load", busy, 1);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(90, "load_plain");

    // restart from DONE with 5 wait states on word 3
    ws_left = 5;
    issue_load(1'b1);
    wait_done(95, "load_ws");
    check("w3_stall_cycles", 64'(w3_stalls), 5);
    check("w3_accepts", 64'(w3_accepts), 1);

    // a_full[2] stall during word 2 unpack cycles 4..9
    stall_en = 1'b1;
    issue_load(1'b1);
    wait_done(96, "load_stall");

    // reset mid word-5 unpack, then reload from word 0
    issue_load(1'b1);
    guard = 0;
    while (a_cnt[5] < 2 && guard < 400) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("rst_trigger", 64'(a_cnt[5] >= 2), 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    wr_q.delete();
    addr_q.delete();
    @(posedge clk);
    #1;
    check("midrst_hold_wren", a_wren_out, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_busy", busy, 0);
    check("postrst_done", done, 0);
    issue_load(1'b1);
    wait_done(90, "load_after_rst");

`ifdef LOADER_ERR_EN
    // no response to word 0: err after 256 WAIT cycles, start recovers
    no_resp_w0 = 1'b1;
    issue_load(1'b0);
    begin
      time t1;
      t1 = t0;
      guard = 0;
      while (!err && guard < 600) begin
        @(posedge clk);
        t1 = $time;
        #1;
        guard++;
      end
      check("err_latency", 64'((t1 - t0) / 10), 257);
      check("err_busy", busy, 0);
      check("err_done", done, 0);
    end
    no_resp_w0 = 1'b0;
    issue_load(1'b1);
    check("err_cleared", err, 0);
    wait_done(90, "load_after_err");
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
